// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic valid/ready pipeline-stage register carrying an
// instruction word, PC and sideband payload between two core stages.
// Supports back-pressure, flush with NOP-bubble insertion and an occupancy
// count.
// Optional feature macro: PIPE_SKID_EN. When defined, a second (skid) entry is
// added so that ready_o becomes a pure register output with no combinational
// path from ready_i. When undefined, the stage holds a single entry.
module pipe_stage_reg #(
    parameter int                 INST_W   = 32,
    parameter int                 ADDR_W   = 32,
    parameter int                 SIDE_W   = 8,
    parameter logic [INST_W-1:0]  NOP_INST = INST_W'(32'h0000_0013)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [INST_W-1:0] instr_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [SIDE_W-1:0] side_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [INST_W-1:0] instr_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [SIDE_W-1:0] side_o,
    output logic [1:0]        count_o
);

    // Main entry M: drives the outputs directly
    logic              vld_p0;
    logic [INST_W-1:0] instr_p0;
    logic [ADDR_W-1:0] pc_p0;
    logic [SIDE_W-1:0] side_p0;
    logic [1:0]        cnt_p0;

    logic              vld_p0_nxt;
    logic [INST_W-1:0] instr_p0_nxt;
    logic [ADDR_W-1:0] pc_p0_nxt;
    logic [SIDE_W-1:0] side_p0_nxt;
    logic [1:0]        cnt_p0_nxt;

    logic              accept;
    logic              release_m;

`ifdef PIPE_SKID_EN
    // Skid entry S: only ever occupied while M is also occupied
    logic              vld_p1;
    logic [INST_W-1:0] instr_p1;
    logic [ADDR_W-1:0] pc_p1;
    logic [SIDE_W-1:0] side_p1;
    logic              rdy_p0;

    logic              vld_p1_nxt;
    logic              load_p1;

    assign ready_o = rdy_p0;
`else
    // Single entry: can take a beat whenever M is empty or draining this cycle
    assign ready_o = ready_i || !vld_p0;
`endif

    assign accept    = valid_i && ready_o;
    assign release_m = vld_p0 && ready_i;

    // Next-state selection for occupancy and main-entry payload; flush wins
    always_comb begin
        vld_p0_nxt   = vld_p0;
        instr_p0_nxt = instr_p0;
        pc_p0_nxt    = pc_p0;
        side_p0_nxt  = side_p0;
`ifdef PIPE_SKID_EN
        vld_p1_nxt   = vld_p1;
        load_p1      = 1'b0;
`endif
        if (flush_i) begin
            // Bubble insertion: pc is left holding its last value
            vld_p0_nxt   = 1'b0;
            instr_p0_nxt = NOP_INST;
            side_p0_nxt  = '0;
`ifdef PIPE_SKID_EN
            vld_p1_nxt   = 1'b0;
`endif
        end else if (!vld_p0 || release_m) begin
`ifdef PIPE_SKID_EN
            if (vld_p1) begin
                // Oldest beat moves forward; a new beat backfills the skid slot
                vld_p0_nxt   = 1'b1;
                instr_p0_nxt = instr_p1;
                pc_p0_nxt    = pc_p1;
                side_p0_nxt  = side_p1;
                vld_p1_nxt   = accept;
                load_p1      = accept;
            end else
`endif
            if (accept) begin
                vld_p0_nxt   = 1'b1;
                instr_p0_nxt = instr_i;
                pc_p0_nxt    = pc_i;
                side_p0_nxt  = side_i;
            end else begin
                vld_p0_nxt   = 1'b0;
                instr_p0_nxt = NOP_INST;
                side_p0_nxt  = '0;
            end
        end else begin
`ifdef PIPE_SKID_EN
            // M stalled: an accepted beat can only be parked in S
            if (accept) begin
                vld_p1_nxt = 1'b1;
                load_p1    = 1'b1;
            end
`endif
        end

`ifdef PIPE_SKID_EN
        cnt_p0_nxt = {vld_p1_nxt, vld_p0_nxt && !vld_p1_nxt};
`else
        cnt_p0_nxt = {1'b0, vld_p0_nxt};
`endif
    end

    // Main-entry registers; reset clears them so idle outputs read as a bubble
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p0   <= 1'b0;
            instr_p0 <= NOP_INST;
            pc_p0    <= '0;
            side_p0  <= '0;
            cnt_p0   <= 2'd0;
        end else begin
            vld_p0   <= vld_p0_nxt;
            instr_p0 <= instr_p0_nxt;
            pc_p0    <= pc_p0_nxt;
            side_p0  <= side_p0_nxt;
            cnt_p0   <= cnt_p0_nxt;
        end
    end

`ifdef PIPE_SKID_EN
    // Skid occupancy and registered ready (low only when both entries are full)
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p1 <= 1'b0;
            rdy_p0 <= 1'b1;
        end else begin
            vld_p1 <= vld_p1_nxt;
            rdy_p0 <= !vld_p1_nxt;
        end
    end

    // Skid payload is only meaningful while vld_p1 is set, so it is not reset
    always_ff @(posedge clk_i) begin
        if (load_p1) begin
            instr_p1 <= instr_i;
            pc_p1    <= pc_i;
            side_p1  <= side_i;
        end
    end
`endif

    assign valid_o = vld_p0;
    assign instr_o = instr_p0;
    assign pc_o    = pc_p0;
    assign side_o  = side_p0;
    assign count_o = cnt_p0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: self-checking bench for pipe_stage_reg. A scoreboard
// queue records every accepted beat and is compared against each released
// beat; scenario tasks add direct checks on occupancy, ready and stall/flush
// behaviour. Skid-specific scenarios are selected by PIPE_SKID_EN.
module tb_pipe_stage_reg;

    localparam int          INST_W = 32;
    localparam int          ADDR_W = 32;
    localparam int          SIDE_W = 8;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef struct packed {
        logic [INST_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
        logic [SIDE_W-1:0] side;
    } beat_t;

    logic              clk_i;
    logic              rst_i;
    logic              valid_i;
    logic              ready_o;
    logic [INST_W-1:0] instr_i;
    logic [ADDR_W-1:0] pc_i;
    logic [SIDE_W-1:0] side_i;
    logic              flush_i;
    logic              valid_o;
    logic              ready_i;
    logic [INST_W-1:0] instr_o;
    logic [ADDR_W-1:0] pc_o;
    logic [SIDE_W-1:0] side_o;
    logic [1:0]        count_o;

    beat_t sb_q[$];
    int    total = 0;
    int    bad   = 0;

    pipe_stage_reg #(
        .INST_W  (INST_W),
        .ADDR_W  (ADDR_W),
        .SIDE_W  (SIDE_W),
        .NOP_INST(NOP)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .instr_i(instr_i),
        .pc_i   (pc_i),
        .side_i (side_i),
        .flush_i(flush_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .instr_o(instr_o),
        .pc_o   (pc_o),
        .side_o (side_o),
        .count_o(count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Payload derived from the PC so every beat is distinguishable
    function automatic beat_t mk(input logic [ADDR_W-1:0] pc);
        beat_t b;
        b.instr = 32'hA500_0000 ^ pc;
        b.pc    = pc;
        b.side  = pc[7:0] ^ 8'h5A;
        return b;
    endfunction

    task automatic drive(input logic [ADDR_W-1:0] pc);
        beat_t b;
        b       = mk(pc);
        valid_i = 1'b1;
        instr_i = b.instr;
        pc_i    = b.pc;
        side_i  = b.side;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Scoreboard monitor: inputs are stable at the falling edge, so this
    // predicts what the next rising edge will accept and release.
    always @(negedge clk_i) begin
        beat_t exp_b;
        if (!rst_i) begin
            if (!valid_o) begin
                total++;
                if (instr_o !== NOP || side_o !== '0) begin
                    bad++;
                    $display("FAIL idle_bubble: instr_o=%h side_o=%h, want %h/00", instr_o, side_o, NOP);
                end
            end
            if (flush_i) begin
                sb_q.delete();
            end else begin
                if (valid_o && ready_i) begin
                    total++;
                    if (sb_q.size() == 0) begin
                        bad++;
                        $display("FAIL sb_spurious: released pc_o=%h with nothing expected", pc_o);
                    end else begin
                        exp_b = sb_q.pop_front();
                        if ({instr_o, pc_o, side_o} !== exp_b) begin
                            bad++;
                            $display("FAIL sb_order: got instr=%h pc=%h side=%h, want instr=%h pc=%h side=%h",
                                     instr_o, pc_o, side_o, exp_b.instr, exp_b.pc, exp_b.side);
                        end
                    end
                end
                if (valid_i && ready_o) sb_q.push_back({instr_i, pc_i, side_i});
            end
        end
    end

    task automatic test_reset();
        total++;
        if (valid_o !== 1'b0 || instr_o !== NOP || pc_o !== '0 || side_o !== '0 || count_o !== 2'd0 || ready_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_initial: v=%b i=%h pc=%h s=%h c=%0d r=%b", valid_o, instr_o, pc_o, side_o, count_o, ready_o);
        end
        tick();
        rst_i   = 1'b0;
        ready_i = 1'b0;
        drive(32'h100);
        tick();
        valid_i = 1'b0;
        total++;
        if (valid_o !== 1'b1 || pc_o !== 32'h100 || count_o !== 2'd1) begin
            bad++;
            $display("FAIL reset_first_accept: v=%b pc=%h c=%0d, want 1/100/1", valid_o, pc_o, count_o);
        end
        #2;
        rst_i = 1'b1;
        #1;
        total++;
        if (valid_o !== 1'b0 || instr_o !== NOP || pc_o !== '0 || side_o !== '0 || count_o !== 2'd0 || ready_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_async: v=%b i=%h pc=%h s=%h c=%0d r=%b", valid_o, instr_o, pc_o, side_o, count_o, ready_o);
        end
        sb_q.delete();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_stream();
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(32'(i * 4));
            tick();
            total++;
            if (valid_o !== 1'b1 || pc_o !== 32'(i * 4) || count_o !== 2'd1) begin
                bad++;
                $display("FAIL stream_%0d: v=%b pc=%h c=%0d, want 1/%h/1", i, valid_o, pc_o, count_o, i * 4);
            end
        end
        valid_i = 1'b0;
        tick();
        total++;
        if (valid_o !== 1'b0 || count_o !== 2'd0) begin
            bad++;
            $display("FAIL stream_drain: v=%b c=%0d, want 0/0", valid_o, count_o);
        end
    endtask

`ifdef PIPE_SKID_EN
    task automatic test_backpressure();
        ready_i = 1'b1;
        drive(32'h10);
        tick();
        ready_i = 1'b0;
        drive(32'h14);
        tick();
        total++;
        if (count_o !== 2'd2 || ready_o !== 1'b0 || pc_o !== 32'h10) begin
            bad++;
            $display("FAIL bp_skid_full: c=%0d r=%b pc=%h, want 2/0/10", count_o, ready_o, pc_o);
        end
        drive(32'h18);
        tick();
        total++;
        if (count_o !== 2'd2 || ready_o !== 1'b0 || pc_o !== 32'h10 || valid_o !== 1'b1) begin
            bad++;
            $display("FAIL bp_skid_hold: c=%0d r=%b pc=%h v=%b, want 2/0/10/1", count_o, ready_o, pc_o, valid_o);
        end
        ready_i = 1'b1;
        tick();
        total++;
        if (pc_o !== 32'h14 || count_o !== 2'd1 || ready_o !== 1'b1) begin
            bad++;
            $display("FAIL bp_skid_move: pc=%h c=%0d r=%b, want 14/1/1", pc_o, count_o, ready_o);
        end
        tick();
        valid_i = 1'b0;
        total++;
        if (pc_o !== 32'h18 || count_o !== 2'd1) begin
            bad++;
            $display("FAIL bp_skid_last: pc=%h c=%0d, want 18/1", pc_o, count_o);
        end
        tick();
        total++;
        if (valid_o !== 1'b0 || count_o !== 2'd0) begin
            bad++;
            $display("FAIL bp_skid_drain: v=%b c=%0d, want 0/0", valid_o, count_o);
        end
    endtask
`else
    task automatic test_backpressure();
        ready_i = 1'b1;
        drive(32'h10);
        tick();
        ready_i = 1'b0;
        drive(32'h14);
        #1;
        total++;
        if (ready_o !== 1'b0) begin
            bad++;
            $display("FAIL bp_ready_comb: ready_o=%b, want 0", ready_o);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (valid_o !== 1'b1 || {instr_o, pc_o, side_o} !== mk(32'h10) || ready_o !== 1'b0 || count_o !== 2'd1) begin
                bad++;
                $display("FAIL bp_stall_%0d: v=%b pc=%h i=%h r=%b c=%0d, want beat 10 held", i, valid_o, pc_o, instr_o, ready_o, count_o);
            end
        end
        ready_i = 1'b1;
        #1;
        total++;
        if (ready_o !== 1'b1) begin
            bad++;
            $display("FAIL bp_ready_release: ready_o=%b, want 1", ready_o);
        end
        tick();
        valid_i = 1'b0;
        total++;
        if (pc_o !== 32'h14 || valid_o !== 1'b1) begin
            bad++;
            $display("FAIL bp_next: pc=%h v=%b, want 14/1", pc_o, valid_o);
        end
        tick();
        total++;
        if (valid_o !== 1'b0) begin
            bad++;
            $display("FAIL bp_drain: v=%b, want 0", valid_o);
        end
    endtask
`endif

    task automatic test_flush();
        logic [1:0] want_cnt;
`ifdef PIPE_SKID_EN
        want_cnt = 2'd2;
`else
        want_cnt = 2'd1;
`endif
        ready_i = 1'b1;
        drive(32'h30);
        tick();
        ready_i = 1'b0;
        drive(32'h34);
        tick();
        total++;
        if (count_o !== want_cnt) begin
            bad++;
            $display("FAIL flush_prefill: c=%0d, want %0d", count_o, want_cnt);
        end
        flush_i = 1'b1;
        drive(32'h40);
        tick();
        flush_i = 1'b0;
        valid_i = 1'b0;
        total++;
        if (valid_o !== 1'b0 || count_o !== 2'd0 || instr_o !== NOP || side_o !== '0 || pc_o !== 32'h30 || ready_o !== 1'b1) begin
            bad++;
            $display("FAIL flush_clear: v=%b c=%0d i=%h s=%h pc=%h r=%b, want 0/0/%h/00/30/1",
                     valid_o, count_o, instr_o, side_o, pc_o, ready_o, NOP);
        end
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (valid_o !== 1'b0 || pc_o === 32'h40) begin
                bad++;
                $display("FAIL flush_ghost_%0d: v=%b pc=%h, want no beat", i, valid_o, pc_o);
            end
        end
    endtask

    task automatic test_back_to_back();
        ready_i = 1'b0;
        drive(32'h7C);
        tick();
        ready_i = 1'b1;
        drive(32'h80);
        tick();
        valid_i = 1'b0;
        total++;
        if (pc_o !== 32'h80 || count_o !== 2'd1 || valid_o !== 1'b1) begin
            bad++;
            $display("FAIL b2b_swap: pc=%h c=%0d v=%b, want 80/1/1", pc_o, count_o, valid_o);
        end
        tick();
        total++;
        if (valid_o !== 1'b0 || count_o !== 2'd0) begin
            bad++;
            $display("FAIL b2b_drain: v=%b c=%0d, want 0/0", valid_o, count_o);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i   = 1'b1;
        valid_i = 1'b0;
        instr_i = '0;
        pc_i    = '0;
        side_i  = '0;
        flush_i = 1'b0;
        ready_i = 1'b0;
        #12;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_back_to_back();
        tick();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: %0d beats never delivered, want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
